// File: rtl/exc_pkg.sv
// Shared constants for the MEM-stage exception controller: exception codes,
// CP0 register addresses, bad-address source selects and FSM states.
package exc_pkg;

    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
    localparam logic [31:0] EXC_ADES = 32'h0000_0005;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_BP   = 32'h0000_0009;
    localparam logic [31:0] EXC_RI   = 32'h0000_000a;
    localparam logic [31:0] EXC_OV   = 32'h0000_000c;
    localparam logic [31:0] EXC_TR   = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET = 32'h0000_000e;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

    // Where bad_addr_o comes from for the selected exception.
    localparam logic [1:0] BAD_NONE = 2'd0;
    localparam logic [1:0] BAD_PC   = 2'd1;
    localparam logic [1:0] BAD_MEM  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TAKE  = 2'd1,
        ST_FLUSH = 2'd2
    } exc_state_t;

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority exception encoder; purely combinational, no backpressure.
// Produces detect, exception code and the bad-address source select.
module exc_prio_enc
    import exc_pkg::*;
(
    input  logic        i_valid,
    input  logic        i_int,
    input  logic        i_adel_if,
    input  logic        i_ri,
    input  logic        i_ov,
    input  logic        i_trap,
    input  logic        i_syscall,
    input  logic        i_break,
    input  logic        i_adel,
    input  logic        i_ades,
    input  logic        i_eret,
    output logic        o_detect,
    output logic [31:0] o_code,
    output logic [1:0]  o_bad_sel
);

    always_comb begin
        o_detect  = 1'b0;
        o_code    = '0;
        o_bad_sel = BAD_NONE;
        if (i_valid) begin
            o_detect = 1'b1;
            if (i_int)            o_code = EXC_INT;
            else if (i_adel_if) begin
                o_code    = EXC_ADEL;
                o_bad_sel = BAD_PC;
            end
            else if (i_ri)        o_code = EXC_RI;
            else if (i_ov)        o_code = EXC_OV;
            else if (i_trap)      o_code = EXC_TR;
            else if (i_syscall)   o_code = EXC_SYS;
            else if (i_break)     o_code = EXC_BP;
            else if (i_adel) begin
                o_code    = EXC_ADEL;
                o_bad_sel = BAD_MEM;
            end
            else if (i_ades) begin
                o_code    = EXC_ADES;
                o_bad_sel = BAD_MEM;
            end
            else if (i_eret)      o_code = EXC_ERET;
            else                  o_detect = 1'b0;
        end
    end

endmodule

// File: rtl/exception_ctrl.sv
// MEM-stage exception arbiter: one-cycle event to CP0 then FLUSH_CYCLES of flush.
// Latency 1 cycle from detection; stall_i defers the event while holding the kill.
module exception_ctrl
    import exc_pkg::*;
#(
    parameter int          FLUSH_CYCLES = 2,
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic [31:0] pc_i,
    input  logic        in_delayslot_i,
    input  logic [31:0] mem_addr_i,
    input  logic        adel_if_i,
    input  logic        ri_i,
    input  logic        ov_i,
    input  logic        trap_i,
    input  logic        syscall_i,
    input  logic        break_i,
    input  logic        adel_i,
    input  logic        ades_i,
    input  logic        eret_i,
    input  logic        stall_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic        cp0_we_wb_i,
    input  logic [4:0]  cp0_waddr_wb_i,
    input  logic [31:0] cp0_wdata_wb_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic [31:0] bad_addr_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        mem_we_kill_o
);

    localparam int CNT_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);

    exc_state_t       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_code, r_pc, r_bad, r_new_pc;
    logic             r_ds;

    logic [31:0] w_status_f, w_cause_f, w_epc_f;
    logic        w_int, w_detect, w_accept, w_unused;
    logic [31:0] w_code, w_bad_addr, w_new_pc;
    logic [1:0]  w_bad_sel;

    // Honour an mtc0 sitting in WB this cycle; only IP[1:0] of cause is writable.
    assign w_status_f = (cp0_we_wb_i && cp0_waddr_wb_i == CP0_STATUS) ? cp0_wdata_wb_i : status_i;
    assign w_epc_f    = (cp0_we_wb_i && cp0_waddr_wb_i == CP0_EPC)    ? cp0_wdata_wb_i : epc_i;
    assign w_cause_f  = {cause_i[31:10],
                         (cp0_we_wb_i && cp0_waddr_wb_i == CP0_CAUSE) ? cp0_wdata_wb_i[9:8] : cause_i[9:8],
                         cause_i[7:0]};

    assign w_int    = (|(w_cause_f[15:8] & w_status_f[15:8])) & w_status_f[0] & ~w_status_f[1];
    assign w_unused = ^{w_status_f[31:16], w_status_f[7:2], w_cause_f[31:16], w_cause_f[7:0]};

    exc_prio_enc u_prio (
        .i_valid   (mem_valid_i),
        .i_int     (w_int),
        .i_adel_if (adel_if_i),
        .i_ri      (ri_i),
        .i_ov      (ov_i),
        .i_trap    (trap_i),
        .i_syscall (syscall_i),
        .i_break   (break_i),
        .i_adel    (adel_i),
        .i_ades    (ades_i),
        .i_eret    (eret_i),
        .o_detect  (w_detect),
        .o_code    (w_code),
        .o_bad_sel (w_bad_sel)
    );

    assign w_bad_addr = (w_bad_sel == BAD_PC)  ? pc_i :
                        (w_bad_sel == BAD_MEM) ? mem_addr_i : '0;
    assign w_new_pc   = (w_code == EXC_ERET) ? w_epc_f : EXC_VECTOR;
    assign w_accept   = (r_state == ST_IDLE) && w_detect && !stall_i;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_nxt = ST_TAKE;
            ST_TAKE:  w_state_nxt = (FLUSH_CYCLES == 1) ? ST_IDLE : ST_FLUSH;
            ST_FLUSH: if (r_cnt == '0) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_code   <= '0;
            r_pc     <= '0;
            r_ds     <= 1'b0;
            r_bad    <= '0;
            r_new_pc <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_code   <= w_code;
                r_pc     <= pc_i;
                r_ds     <= in_delayslot_i;
                r_bad    <= w_bad_addr;
                r_new_pc <= w_new_pc;
            end
            if (r_state == ST_TAKE)
                r_cnt <= CNT_INIT;
            else if (r_state == ST_FLUSH && r_cnt != '0)
                r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign excepttype_o        = (r_state == ST_TAKE) ? r_code : '0;
    assign current_inst_addr_o = (r_state == ST_TAKE) ? r_pc   : '0;
    assign is_in_delayslot_o   = (r_state == ST_TAKE) && r_ds;
    assign bad_addr_o          = (r_state == ST_TAKE) ? r_bad  : '0;
    assign flush_o             = (r_state != ST_IDLE);
    assign new_pc_o            = flush_o ? r_new_pc : '0;
    assign mem_we_kill_o       = ((r_state == ST_IDLE) && w_detect) || (r_state != ST_IDLE);

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl with a cycle-level reference model and literal spot checks.
module tb_exception_ctrl;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid_i, in_delayslot_i, stall_i, cp0_we_wb_i;
    logic        adel_if_i, ri_i, ov_i, trap_i, syscall_i, break_i, adel_i, ades_i, eret_i;
    logic [31:0] pc_i, mem_addr_i, status_i, cause_i, epc_i, cp0_wdata_wb_i;
    logic [4:0]  cp0_waddr_wb_i;
    logic [31:0] excepttype_o, current_inst_addr_o, bad_addr_o, new_pc_o;
    logic        is_in_delayslot_o, flush_o, mem_we_kill_o;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: remaining flush cycles and the latched event.
    bit          m_valid = 0;
    int          m_left  = 0;
    bit          m_first = 0;
    logic [31:0] m_code, m_pc, m_bad, m_npc;
    logic        m_ds;

    exception_ctrl #(.FLUSH_CYCLES(FC), .EXC_VECTOR(32'hBFC00380)) dut (
        .clk(clk), .rst(rst), .mem_valid_i(mem_valid_i), .pc_i(pc_i),
        .in_delayslot_i(in_delayslot_i), .mem_addr_i(mem_addr_i),
        .adel_if_i(adel_if_i), .ri_i(ri_i), .ov_i(ov_i), .trap_i(trap_i),
        .syscall_i(syscall_i), .break_i(break_i), .adel_i(adel_i), .ades_i(ades_i),
        .eret_i(eret_i), .stall_i(stall_i), .status_i(status_i), .cause_i(cause_i),
        .epc_i(epc_i), .cp0_we_wb_i(cp0_we_wb_i), .cp0_waddr_wb_i(cp0_waddr_wb_i),
        .cp0_wdata_wb_i(cp0_wdata_wb_i), .excepttype_o(excepttype_o),
        .current_inst_addr_o(current_inst_addr_o), .is_in_delayslot_o(is_in_delayslot_o),
        .bad_addr_o(bad_addr_o), .flush_o(flush_o), .new_pc_o(new_pc_o),
        .mem_we_kill_o(mem_we_kill_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Table-driven priority pick straight from the exception table.
    task automatic model_pick(output bit det, output logic [31:0] code,
                              output logic [31:0] bad, output logic [31:0] npc);
        logic [31:0] st, ca, ep;
        bit          src[10];
        logic [31:0] codes[10];
        bit          intr;
        st = status_i; ca = cause_i; ep = epc_i;
        if (cp0_we_wb_i && cp0_waddr_wb_i == 5'd12) st = cp0_wdata_wb_i;
        if (cp0_we_wb_i && cp0_waddr_wb_i == 5'd13) ca[9:8] = cp0_wdata_wb_i[9:8];
        if (cp0_we_wb_i && cp0_waddr_wb_i == 5'd14) ep = cp0_wdata_wb_i;
        intr = ((ca[15:8] & st[15:8]) != 8'h0) && st[0] && !st[1];
        src   = '{intr, adel_if_i, ri_i, ov_i, trap_i, syscall_i, break_i, adel_i, ades_i, eret_i};
        codes = '{32'h1, 32'h4, 32'ha, 32'hc, 32'hd, 32'h8, 32'h9, 32'h4, 32'h5, 32'he};
        det = 0; code = 0; bad = 0; npc = 32'hBFC00380;
        if (mem_valid_i) begin
            for (int i = 9; i >= 0; i--) begin
                if (src[i]) begin
                    det  = 1;
                    code = codes[i];
                    bad  = (i == 1) ? pc_i : (i == 7 || i == 8) ? mem_addr_i : 32'h0;
                    npc  = (i == 9) ? ep : 32'hBFC00380;
                end
            end
        end
    endtask

    // Compare DUT against the model mid-cycle, then advance the model across the edge.
    task automatic model_cycle();
        bit          det;
        logic [31:0] code, bad, npc;
        model_pick(det, code, bad, npc);
        if (m_valid) begin
            chk("m_excepttype", excepttype_o, m_first ? m_code : 32'h0);
            chk("m_flush", {31'h0, flush_o}, {31'h0, m_left > 0});
            chk("m_kill", {31'h0, mem_we_kill_o}, {31'h0, (m_left > 0) || det});
            if (m_left > 0) chk("m_new_pc", new_pc_o, m_npc);
            if (m_first) begin
                chk("m_inst_addr", current_inst_addr_o, m_pc);
                chk("m_delayslot", {31'h0, is_in_delayslot_o}, {31'h0, m_ds});
                chk("m_bad_addr", bad_addr_o, m_bad);
            end
        end
        if (rst) begin
            m_valid = 1; m_left = 0; m_first = 0;
        end else if (m_left > 0) begin
            m_left--; m_first = 0;
        end else if (det && !stall_i) begin
            m_left = FC; m_first = 1;
            m_code = code; m_pc = pc_i; m_ds = in_delayslot_i; m_bad = bad; m_npc = npc;
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        mem_valid_i = 0; pc_i = 0; in_delayslot_i = 0; mem_addr_i = 0;
        adel_if_i = 0; ri_i = 0; ov_i = 0; trap_i = 0; syscall_i = 0; break_i = 0;
        adel_i = 0; ades_i = 0; eret_i = 0; stall_i = 0;
        status_i = 0; cause_i = 0; epc_i = 0;
        cp0_we_wb_i = 0; cp0_waddr_wb_i = 0; cp0_wdata_wb_i = 0;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_excepttype"}, excepttype_o, 32'h0);
        chk({tag, "_flush"}, {31'h0, flush_o}, 32'h0);
        chk({tag, "_new_pc"}, new_pc_o, 32'h0);
        chk({tag, "_inst_addr"}, current_inst_addr_o, 32'h0);
        chk({tag, "_bad_addr"}, bad_addr_o, 32'h0);
        chk({tag, "_delayslot"}, {31'h0, is_in_delayslot_o}, 32'h0);
    endtask

    task automatic one_event(input logic [31:0] exp_code, input string tag);
        step();
        clear_in();
        chk({tag, "_code"}, excepttype_o, exp_code);
        step();
        step();
    endtask

    initial begin
        clear_in();
        rst = 1;
        step(); step();
        rst = 0;
        #1;
        all_zero("reset");
        chk("reset_kill", {31'h0, mem_we_kill_o}, 32'h0);

        // Syscall, no stall.
        mem_valid_i = 1; pc_i = 32'hBFC00100; syscall_i = 1;
        #1 chk("sys_kill_pre", {31'h0, mem_we_kill_o}, 32'h1);
        step();
        clear_in();
        chk("sys_code", excepttype_o, 32'h8);
        chk("sys_pc", current_inst_addr_o, 32'hBFC00100);
        chk("sys_flush1", {31'h0, flush_o}, 32'h1);
        chk("sys_new_pc", new_pc_o, 32'hBFC00380);
        step();
        chk("sys_code_drop", excepttype_o, 32'h0);
        chk("sys_flush2", {31'h0, flush_o}, 32'h1);
        step();
        chk("sys_flush_end", {31'h0, flush_o}, 32'h0);

        // Misaligned load held by a 3-cycle stall.
        mem_valid_i = 1; pc_i = 32'h80000010; adel_i = 1; mem_addr_i = 32'h80000003; stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_kill", {31'h0, mem_we_kill_o}, 32'h1);
            step();
            chk("stall_no_event", excepttype_o, 32'h0);
        end
        stall_i = 0;
        step();
        clear_in();
        chk("adel_code", excepttype_o, 32'h4);
        chk("adel_bad", bad_addr_o, 32'h80000003);
        step(); step();

        // Interrupt beats overflow; EXL masks it.
        mem_valid_i = 1; status_i = 32'h0000FF01; cause_i = 32'h00000400; ov_i = 1;
        one_event(32'h1, "int_over_ov");
        mem_valid_i = 1; status_i = 32'h0000FF03; cause_i = 32'h00000400; ov_i = 1;
        one_event(32'hc, "exl_masks_int");

        // Status forwarded from WB enables the interrupt.
        mem_valid_i = 1; cause_i = 32'h00000400; ri_i = 1;
        cp0_we_wb_i = 1; cp0_waddr_wb_i = 5'd12; cp0_wdata_wb_i = 32'h0000FF01;
        one_event(32'h1, "fwd_status");
        // Software interrupt bit forwarded into cause.
        mem_valid_i = 1; status_i = 32'h00000101; syscall_i = 1;
        cp0_we_wb_i = 1; cp0_waddr_wb_i = 5'd13; cp0_wdata_wb_i = 32'h00000100;
        one_event(32'h1, "fwd_cause");

        // eret with EPC written in WB.
        mem_valid_i = 1; eret_i = 1; epc_i = 32'hDEAD0000;
        cp0_we_wb_i = 1; cp0_waddr_wb_i = 5'd14; cp0_wdata_wb_i = 32'h80001234;
        step();
        clear_in();
        chk("eret_code", excepttype_o, 32'he);
        chk("eret_new_pc", new_pc_o, 32'h80001234);
        step();
        chk("eret_new_pc_held", new_pc_o, 32'h80001234);
        step();

        // Syscall then breaks in the flush window.
        mem_valid_i = 1; pc_i = 32'h80000100; syscall_i = 1;
        step();
        syscall_i = 0; break_i = 1; pc_i = 32'h80000104;
        chk("sysbrk_code", excepttype_o, 32'h8);
        step();
        chk("sysbrk_ignored", excepttype_o, 32'h0);
        step();
        clear_in();
        #1;
        chk("sysbrk_idle_flush", {31'h0, flush_o}, 32'h0);
        chk("sysbrk_idle_kill", {31'h0, mem_we_kill_o}, 32'h0);

        // Reset during FLUSH, then a normal event.
        mem_valid_i = 1; pc_i = 32'h80000200; syscall_i = 1;
        step();
        clear_in();
        step();
        rst = 1;
        step();
        rst = 0;
        all_zero("rst_flush");
        mem_valid_i = 1; pc_i = 32'h80000300; in_delayslot_i = 1; syscall_i = 1; break_i = 1;
        step();
        clear_in();
        chk("post_rst_code", excepttype_o, 32'h8);
        chk("post_rst_ds", {31'h0, is_in_delayslot_o}, 32'h1);
        chk("post_rst_pc", current_inst_addr_o, 32'h80000300);
        step(); step();

        // Fetch address error outranks store error; bad address is the PC.
        mem_valid_i = 1; pc_i = 32'hBFC00001; adel_if_i = 1; ades_i = 1; mem_addr_i = 32'h00000002;
        step();
        clear_in();
        chk("adelif_code", excepttype_o, 32'h4);
        chk("adelif_bad", bad_addr_o, 32'hBFC00001);
        step(); step();
        mem_valid_i = 1; pc_i = 32'h80000400; ades_i = 1; mem_addr_i = 32'h80000006;
        step();
        clear_in();
        chk("ades_code", excepttype_o, 32'h5);
        chk("ades_bad", bad_addr_o, 32'h80000006);
        step(); step();
        mem_valid_i = 1; trap_i = 1; syscall_i = 1;
        one_event(32'hd, "trap");

        // Flags on a bubble are ignored.
        mem_valid_i = 0; syscall_i = 1; ov_i = 1;
        #1 chk("bubble_kill", {31'h0, mem_we_kill_o}, 32'h0);
        step();
        chk("bubble_no_event", {31'h0, flush_o}, 32'h0);
        clear_in();
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/exception_ctrl.md
# exception_ctrl

MEM-stage exception arbiter and flush sequencer for the MIPS pipeline. Collects per-instruction exception flags and pending interrupts, picks one by fixed priority and issues exactly one single-cycle exception event to the CP0 register block (`excepttype`, faulting PC, delay-slot flag, bad address). It then drives a multi-cycle pipeline flush with the redirect PC. CP0 `status`/`cause`/`epc` are read back with WB-stage write forwarding, so in-flight `mtc0` results are honoured.

## Interface
Parameters:
- `FLUSH_CYCLES`, 2: number of cycles `flush_o` is held per taken event (must be ≥1).
- `EXC_VECTOR`, 32'hBFC00380: redirect PC for every exception other than eret.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  reset, synchronous, active-high.
- `mem_valid_i`  in  1  a real instruction is in MEM this cycle.
- `pc_i`  in  32  PC of the MEM instruction.
- `in_delayslot_i`  in  1  MEM instruction is in a delay slot.
- `mem_addr_i`  in  32  data address of the MEM load/store.
- `adel_if_i`, `ri_i`, `ov_i`, `trap_i`, `syscall_i`, `break_i`, `adel_i`, `ades_i`, `eret_i`  in  1 each  exception flags of the MEM instruction.
- `stall_i`  in  1  pipeline held (e.g. data memory busy).
- `status_i`, `cause_i`, `epc_i`  in  32 each  current CP0 values.
- `cp0_we_wb_i`  in  1  CP0 write in WB.
- `cp0_waddr_wb_i`  in  5  CP0 write address in WB.
- `cp0_wdata_wb_i`  in  32  CP0 write data in WB.
- `excepttype_o`  out  32  exception code to CP0; nonzero for exactly one cycle per event.
- `current_inst_addr_o`  out  32  faulting PC.
- `is_in_delayslot_o`  out  1  delay-slot flag of the faulting instruction.
- `bad_addr_o`  out  32  BadVAddr value.
- `flush_o`  out  1  flush all pipeline registers.
- `new_pc_o`  out  32  redirect target; valid while `flush_o` is high.
- `mem_we_kill_o`  out  1  suppress the MEM-stage store and the register write (combinational).

## Operation
- Forwarded CP0 values:
  - `status_f` = `cp0_wdata_wb_i` if WB writes reg 12, else `status_i`.
  - `cause_f` = `cause_i`, with bits [9:8] taken from WB data if WB writes reg 13.
  - `epc_f` = `cp0_wdata_wb_i` if WB writes reg 14, else `epc_i`.
- Interrupt pending: `|(cause_f[15:8] & status_f[15:8])` & `status_f[0]` & ~`status_f[1]`.
- Detection requires `mem_valid_i`. Priority, highest first:

| Priority | Source | Code | `bad_addr_o` |
|---|---|---|---|
| 1 | interrupt | 0x1 | — |
| 2 | `adel_if` | 0x4 | `pc_i` |
| 3 | `ri` | 0xa | — |
| 4 | `ov` | 0xc | — |
| 5 | `trap` | 0xd | — |
| 6 | `syscall` | 0x8 | — |
| 7 | `break` | 0x9 | — |
| 8 | `adel` | 0x4 | `mem_addr_i` |
| 9 | `ades` | 0x5 | `mem_addr_i` |
| 10 | `eret` | 0xe | — |

- `bad_addr_o` is 0 for every code without an address.
- `new_pc_o` = `epc_f` for eret, `EXC_VECTOR` otherwise.
- FSM states:
  - IDLE: if detect & ~`stall_i`, register code, PC, delay-slot flag, bad address and `new_pc`, then go to TAKE. If detect & `stall_i`, stay in IDLE and re-evaluate each cycle.
  - TAKE: `excepttype_o`, `current_inst_addr_o`, `is_in_delayslot_o` and `bad_addr_o` show the latched values; `flush_o`=1. If `FLUSH_CYCLES`=1 go to IDLE, else go to FLUSH with counter = `FLUSH_CYCLES`-2.
  - FLUSH: `excepttype_o`=0, `flush_o`=1, `new_pc_o` held. The counter decrements; at 0 go to IDLE. `mem_valid_i` and all flags are ignored.
- `mem_we_kill_o` = (IDLE & detect) | (state≠IDLE).
- Delay-slot EPC adjustment (−4) is done by CP0, not here; the PC passes through unchanged.

## Timing
- Reset values: state IDLE, counter 0, all outputs 0 (`new_pc_o`=0).
- `rst` in any state forces IDLE and zero outputs on the next edge; no partial event is emitted.
- Latency: detected in cycle N with `stall_i`=0 → `excepttype_o` and `flush_o` in N+1.
- `flush_o` is high for N+1 … N+`FLUSH_CYCLES`; the next detection is possible at N+`FLUSH_CYCLES`+1.
- Stall: the event is deferred and the kill is held until the first cycle with `stall_i`=0. Exactly one pulse results.
- A flag arriving during TAKE or FLUSH is discarded (the instruction is being flushed).
- Forwarding uses same-cycle WB data; the CP0 EXL update lands at N+2, hidden by the flush window.

## Structure
- Shared package `exc_pkg` (or `defines2.vh` additions):
  - exception code constants;
  - CP0 register addresses 12/13/14;
  - FSM state encoding;
  - `EXC_VECTOR` default.
- Sub-module `exc_prio_enc`: purely combinational priority encoder producing `{detect, code, bad_addr_sel}`.
- FSM, counter, forwarding and output registers live in `exception_ctrl`.

## Test plan
- Syscall at `pc_i`=0xBFC00100, not in a delay slot, no stall → next cycle: `excepttype_o`=0x8, `current_inst_addr_o`=0xBFC00100, `flush_o`=1, `new_pc_o`=0xBFC00380. `flush_o` stays high 2 cycles; the code pulse lasts 1 cycle.
- Load misaligned, `mem_addr_i`=0x80000003, `stall_i`=1 for 3 cycles → `mem_we_kill_o`=1 throughout and no event. After the stall drops: a single `excepttype_o`=0x4 pulse with `bad_addr_o`=0x80000003.
- `status_i`=0x0000FF01, `cause_i[10]`=1, `ov_i`=1 on the same instruction → `excepttype_o`=0x1. Repeat with `status_i`=0x0000FF03 (EXL set) → `excepttype_o`=0xc.
- `eret_i`=1 while WB writes EPC=0x80001234 → `excepttype_o`=0xe, `new_pc_o`=0x80001234.
- Syscall in cycle N, break in N+1 and N+2 → exactly one event (0x8); the break is ignored; the FSM is back in IDLE at N+3.
- `rst` asserted during FLUSH → next cycle all outputs 0 and state IDLE; a syscall after reset release produces a normal event.
